snake_game_ctrl: RTL and testbench

//  Game sequencer for the snake datapath. Drives game_status (RESTART/READY/PLAY/DIE).

---
 rtl/snake_game_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake datapath: start/play/die FSM, food placement from
// two free-running LFSRs, death blink, score and snake length bookkeeping.
module snake_game_ctrl #(
    parameter int BLINK_HALF  = 12_500_000,
    parameter int BLINK_COUNT = 3,
    parameter int INIT_LEN    = 5,
    parameter int MAX_LEN     = 16,
    parameter int FOOD_X0     = 30,
    parameter int FOOD_Y0     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start_n,
    input  logic       hit_wall,
    input  logic       hit_body,
    input  logic [5:0] head_x,
    input  logic [5:0] head_y,
    output logic [1:0] game_status,
    output logic       add_cube,
    output logic       snake_display,
    output logic [5:0] food_x,
    output logic [5:0] food_y,
    output logic       food_valid,
    output logic [7:0] score,
    output logic [4:0] length
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int TW = $clog2(2 * BLINK_COUNT + 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] TOGGLES   = TW'(2 * BLINK_COUNT);
    localparam logic [4:0]    LEN_INIT  = 5'(INIT_LEN);
    localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);
    localparam logic [5:0]    FX0       = 6'(FOOD_X0);
    localparam logic [5:0]    FY0       = 6'(FOOD_Y0);

    typedef enum logic [1:0] {
        ST_RESTART = 2'b00,
        ST_READY   = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic          key_meta_q, key_meta_d, key_sync_q, key_sync_d, key_prev_q, key_prev_d;
    logic [5:0]    lfsr_x_q, lfsr_x_d, lfsr_y_q, lfsr_y_d;
    logic [5:0]    food_x_q, food_x_d, food_y_q, food_y_d;
    logic          food_valid_q, food_valid_d;
    logic          add_cube_q, add_cube_d;
    logic          display_q, display_d;
    logic [7:0]    score_q, score_d;
    logic [4:0]    length_q, length_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [TW-1:0] toggle_cnt_q, toggle_cnt_d;

    logic press, hit, eat, reinit, lfsr_in_range;

    always_comb begin
        press = key_prev_q & ~key_sync_q;
        hit   = hit_wall | hit_body;
        eat   = (state_q == ST_PLAY) && food_valid_q && !hit &&
                (head_x == food_x_q) && (head_y == food_y_q);
        lfsr_in_range = (lfsr_x_q >= 6'd1) && (lfsr_x_q <= 6'd38) &&
                        (lfsr_y_q >= 6'd1) && (lfsr_y_q <= 6'd28);

        state_d      = state_q;
        key_meta_d   = key_start_n;
        key_sync_d   = key_meta_q;
        key_prev_d   = key_sync_q;
        // x uses x^6+x+1, y uses x^6+x^5+1 so the two sequences are not identical
        lfsr_x_d     = {lfsr_x_q[4:0], lfsr_x_q[5] ^ lfsr_x_q[4]};
        lfsr_y_d     = {lfsr_y_q[4:0], lfsr_y_q[5] ^ lfsr_y_q[0]};
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        add_cube_d   = 1'b0;
        display_d    = display_q;
        score_d      = score_q;
        length_d     = length_q;
        blink_cnt_d  = blink_cnt_q;
        toggle_cnt_d = toggle_cnt_q;
        reinit       = 1'b0;

        if (!food_valid_q && lfsr_in_range) begin
            food_x_d     = lfsr_x_q;
            food_y_d     = lfsr_y_q;
            food_valid_d = 1'b1;
        end

        case (state_q)
            ST_RESTART: state_d = ST_READY;
            ST_READY: begin
                if (press) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (hit) begin
                    state_d      = ST_DIE;
                    display_d    = 1'b1;
                    blink_cnt_d  = '0;
                    toggle_cnt_d = '0;
                end else if (eat) begin
                    food_valid_d = 1'b0;
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    if (length_q != LEN_MAX) begin
                        length_d   = length_q + 5'd1;
                        add_cube_d = 1'b1;
                    end
                end
            end
            ST_DIE: begin
                if (toggle_cnt_q != TOGGLES) begin
                    if (blink_cnt_q == HALF_LAST) begin
                        blink_cnt_d  = '0;
                        toggle_cnt_d = toggle_cnt_q + 1'b1;
                        display_d    = ~display_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end else begin
                    display_d = 1'b1;
                    if (press) begin
                        state_d = ST_RESTART;
                        reinit  = 1'b1;
                    end
                end
            end
            default: state_d = ST_RESTART;
        endcase

        // Re-init is applied on entry so RESTART already shows fresh game values
        if (reinit) begin
            score_d      = '0;
            length_d     = LEN_INIT;
            food_x_d     = FX0;
            food_y_d     = FY0;
            food_valid_d = 1'b1;
            display_d    = 1'b1;
            blink_cnt_d  = '0;
            toggle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESTART;
            key_meta_q   <= 1'b1;
            key_sync_q   <= 1'b1;
            key_prev_q   <= 1'b1;
            lfsr_x_q     <= 6'h2D;
            lfsr_y_q     <= 6'h13;
            food_x_q     <= FX0;
            food_y_q     <= FY0;
            food_valid_q <= 1'b1;
            add_cube_q   <= 1'b0;
            display_q    <= 1'b1;
            score_q      <= '0;
            length_q     <= LEN_INIT;
            blink_cnt_q  <= '0;
            toggle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            key_meta_q   <= key_meta_d;
            key_sync_q   <= key_sync_d;
            key_prev_q   <= key_prev_d;
            lfsr_x_q     <= lfsr_x_d;
            lfsr_y_q     <= lfsr_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            add_cube_q   <= add_cube_d;
            display_q    <= display_d;
            score_q      <= score_d;
            length_q     <= length_d;
            blink_cnt_q  <= blink_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    assign game_status   = state_q;
    assign add_cube      = add_cube_q;
    assign snake_display = display_q;
    assign food_x        = food_x_q;
    assign food_y        = food_y_q;
    assign food_valid    = food_valid_q;
    assign score         = score_q;
    assign length        = length_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed game scenarios with randomized head motion,
// checked every cycle against a game-rule model (state, score, length, blink).
module tb_snake_game_ctrl;

    localparam int HALF = 4;
    localparam int BC   = 3;

    logic       clk, rst_n, key_start_n, hit_wall, hit_body;
    logic [5:0] head_x, head_y;
    logic [1:0] game_status;
    logic       add_cube, snake_display, food_valid;
    logic [5:0] food_x, food_y;
    logic [7:0] score;
    logic [4:0] length;

    snake_game_ctrl #(.BLINK_HALF(HALF), .BLINK_COUNT(BC)) dut (
        .clk(clk), .rst_n(rst_n), .key_start_n(key_start_n),
        .hit_wall(hit_wall), .hit_body(hit_body),
        .head_x(head_x), .head_y(head_y),
        .game_status(game_status), .add_cube(add_cube), .snake_display(snake_display),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .score(score), .length(length)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: 0 RESTART, 1 READY, 2 PLAY, 3 DIE
    int m_state, m_score, m_len, m_t;
    bit khist[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_len = 5; m_t = 0;
        khist = '{1'b1, 1'b1, 1'b1};
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_status"}, 32'(game_status), 0);
        check({tag, "_add"}, 32'(add_cube), 0);
        check({tag, "_disp"}, 32'(snake_display), 1);
        check({tag, "_score"}, 32'(score), 0);
        check({tag, "_len"}, 32'(length), 5);
        check({tag, "_fx"}, 32'(food_x), 30);
        check({tag, "_fy"}, 32'(food_y), 15);
        check({tag, "_fv"}, 32'(food_valid), 1);
    endtask

    // Advance one clock, predicting from the game rules, then compare outputs
    task automatic step();
        bit press, hit, eat, exp_add, exp_fv0, exp_init;
        int n, exp_disp;
        n = khist.size();
        press = khist[n-3] && !khist[n-2];
        khist.push_back(key_start_n);
        if (khist.size() > 4) void'(khist.pop_front());
        hit = hit_wall || hit_body;
        eat = (m_state == 2) && (food_valid === 1'b1) && !hit &&
              (head_x == food_x) && (head_y == food_y);
        exp_add = 0; exp_fv0 = 0; exp_init = 0;
        case (m_state)
            0: m_state = 1;
            1: if (press) m_state = 2;
            2: begin
                if (hit) begin
                    m_state = 3; m_t = 0;
                end else if (eat) begin
                    exp_fv0 = 1;
                    if (m_score < 255) m_score++;
                    if (m_len < 16) begin m_len++; exp_add = 1; end
                end
            end
            default: begin
                if (m_t / HALF >= 2 * BC) begin
                    if (press) begin
                        m_state = 0; m_score = 0; m_len = 5; exp_init = 1;
                    end
                end else m_t++;
            end
        endcase
        if (m_state == 3 && m_t / HALF < 2 * BC) exp_disp = ((m_t / HALF) % 2 == 0) ? 1 : 0;
        else exp_disp = 1;
        @(posedge clk);
        #1;
        check("status", 32'(game_status), m_state);
        check("add_cube", 32'(add_cube), 32'(exp_add));
        check("score", 32'(score), m_score);
        check("length", 32'(length), m_len);
        check("display", 32'(snake_display), exp_disp);
        if (exp_fv0) check("food_valid_clear", 32'(food_valid), 0);
        if (exp_init) begin
            check("init_fx", 32'(food_x), 30);
            check("init_fy", 32'(food_y), 15);
            check("init_fv", 32'(food_valid), 1);
        end
        if (food_valid === 1'b1)
            check("food_range", 32'((food_x >= 1) && (food_x <= 38) && (food_y >= 1) && (food_y <= 28)), 1);
    endtask

    task automatic steps(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wait_food();
        for (int i = 0; i < 200 && food_valid !== 1'b1; i++) step();
        check("food_regen_timeout", 32'(food_valid), 1);
    endtask

    task automatic wander(int k);
        for (int i = 0; i < k; i++) begin
            head_x = 6'($urandom_range(39, 63));
            head_y = 6'($urandom_range(0, 63));
            step();
        end
    endtask

    task automatic eat_once();
        wait_food();
        head_x = food_x; head_y = food_y;
        step();
        head_x = 6'd0; head_y = 6'd0;
    endtask

    task automatic press_key();
        key_start_n = 1'b0;
        steps(4);
        key_start_n = 1'b1;
        steps(3);
    endtask

    initial begin
        int pulses, s0;
        rst_n = 1'b0; key_start_n = 1'b1; hit_wall = 1'b0; hit_body = 1'b0;
        head_x = 6'd0; head_y = 6'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        step();
        steps(5);

        $display("[TB] start press, key held 100 cycles");
        key_start_n = 1'b0;
        steps(2);
        check("ready_before_sync", 32'(game_status), 1);
        step();
        check("play_after_3clk", 32'(game_status), 2);
        steps(97);
        key_start_n = 1'b1; steps(5);
        key_start_n = 1'b0; steps(5);
        key_start_n = 1'b1;
        check("play_repress", 32'(game_status), 2);

        $display("[TB] first food, head held 50 cycles");
        head_x = 6'd30; head_y = 6'd15;
        pulses = 0; s0 = m_score;
        for (int i = 0; i < 50; i++) begin
            step();
            if (add_cube === 1'b1) pulses++;
        end
        check("first_eat_score", 32'(score), 32'(s0 + (m_score - s0)));
        check("first_eat_pulses", 32'(pulses), 32'(m_score - s0));
        check("first_eat_len_grew", 32'(length >= 6), 1);
        head_x = 6'd0; head_y = 6'd0;
        wait_food();

        $display("[TB] grow to full length");
        for (int i = 0; i < 40 && m_len < 16; i++) begin
            wander($urandom_range(1, 5));
            eat_once();
        end
        check("full_len", 32'(length), 16);
        s0 = m_score;
        wander(3);
        eat_once();
        check("full_no_add", 32'(add_cube), 0);
        check("full_score_inc", 32'(score), 32'(s0 + 1));
        check("full_len_hold", 32'(length), 16);

        $display("[TB] body hit while on food");
        wait_food();
        s0 = m_score;
        head_x = food_x; head_y = food_y; hit_body = 1'b1;
        step();
        hit_body = 1'b0; head_x = 6'd0; head_y = 6'd0;
        check("hit_die", 32'(game_status), 3);
        check("hit_no_add", 32'(add_cube), 0);
        check("hit_score", 32'(score), 32'(s0));

        steps(9);
        key_start_n = 1'b0; steps(3); key_start_n = 1'b1;
        check("blink_press_ignored", 32'(game_status), 3);
        for (int i = 0; i < 40 && m_t / HALF < 2 * BC; i++) step();
        steps(3);
        check("blink_done_disp", 32'(snake_display), 1);
        key_start_n = 1'b0;
        steps(2);
        step();
        check("restart_state", 32'(game_status), 0);
        step();
        check("restart_ready", 32'(game_status), 1);
        check("restart_score", 32'(score), 0);
        check("restart_len", 32'(length), 5);
        key_start_n = 1'b1; steps(3);

        $display("[TB] second game, wall hit then reset mid-blink");
        press_key();
        check("play2", 32'(game_status), 2);
        wander(10);
        hit_wall = 1'b1;
        step();
        hit_wall = 1'b0;
        check("wall_die", 32'(game_status), 3);
        steps(5);
        check("mid_blink_hidden", 32'(snake_display), 0);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
        steps(3);

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

endmodule
